sgd_dot_product_tx: RTL
=======================

// Module: sgd_dot_product_tx
// PURPOSE
//  Transmit side of the dot-product stream: gathers per-bank signed dot products from the engine,
//  realigns bank-to-bank skew, packs one 32-bit value per bank into a word, and drives it out on
//  an axi_stream master toward the loss stage (ax-b). Buffers against backpressure and applies
//  almost-full flow control to the producing engine.
// PARAMETERS
//  NUM_OF_BANKS     8    banks per word; data width = 32*NUM_OF_BANKS
//  ALIGN_DEPTH      16   per-bank skew FIFO depth (power of 2)
//  OUT_DEPTH        64   packed-word output FIFO depth (power of 2)
//  AF_MARGIN        8    almost_full asserts when free OUT entries <= AF_MARGIN
// PORTS
//  clk                        in   1        single clock domain
//  rst_n                      in   1        asynchronous, active-low reset
//  packet_len                 in   16       words per packet (tlast period); sampled at packet start
//  dot_product_signed[b]      in   32x NB   signed dot product of bank b
//  dot_product_signed_valid[b]in   1 x NB   per-bank valid; banks may be skewed up to ALIGN_DEPTH-1
//  dot_product_almost_full    out  1        engine must stop issuing new valids within 4 cycles
//  m_axis_tx_data             axi_stream.master: valid, ready, data[32*NB-1:0], keep, last
//  tx_overflow                out  1        sticky: a valid arrived on a full align/out FIFO
//  tx_word_cnt                out  32       words accepted by downstream (valid&ready)
// BEHAVIOUR
//  - Reset (async assert, sync deassert internally): all FIFOs empty, m valid=0, last=0,
//    almost_full=0, tx_overflow=0, tx_word_cnt=0, packet word counter=0. Reset mid-packet
//    discards all buffered data; next word after reset starts a new packet.
//  - Align stage: bank b writes its value into align FIFO b on its valid. When all NB align
//    FIFOs non-empty and OUT FIFO not full: pop all in same cycle, pack bank b at data[32b+:32].
//  - Latency: last-arriving bank valid at cycle N -> packed word in OUT FIFO at N+1 ->
//    m valid at N+2 when OUT was empty. Throughput 1 word/cycle sustained with ready=1.
//  - AXI handshake: word transfers on valid&ready. Once valid=1, data/last/keep held stable
//    until accepted; valid never drops without a transfer. keep = all ones.
//  - Packet framing: counter counts accepted words; last=1 on word index L-1, where L =
//    packet_len latched at word 0 of each packet; packet_len=0 treated as 1. Counter wraps to
//    0 after last. Changing packet_len mid-packet affects only the next packet.
//  - Flow control: almost_full = (OUT free <= AF_MARGIN) OR (any align FIFO count >=
//    ALIGN_DEPTH-4). Registered (1-cycle delay).
//  - Boundary: simultaneous pop of align and write of same FIFO when full -> write accepted
//    (pop frees slot). Write to truly full FIFO: data dropped, tx_overflow set until reset.
//    OUT FIFO full with ready=0: align pops stall; no data lost until align FIFOs overflow.
//  - tx_word_cnt wraps at 2^32.
// CONFIGURATION
//  SGD_TX_SATURATE_EN defined: each 32-bit lane replaced by its arithmetic right shift by 0 and
//   clamped to [-2^30, 2^30-1] before packing (protects downstream ax-b from wrap); adds
//   one pipeline cycle (m valid at N+3). Not defined: values passed bit-exact, latency N+2.
// TESTING
//  1 All banks valid same cycle, values b*0x10+1, ready=1, packet_len=4 -> m valid at N+2,
//    data lanes 0x01,0x11..0x71, last on every 4th word, tx_word_cnt=4 per packet.
//  2 Bank 7 valid 5 cycles after banks 0-6 -> single word emitted 2 cycles after bank 7 valid,
//    lane order correct, no duplicate words.
//  3 ready=0 for 100 cycles with continuous input -> almost_full asserts at OUT free<=8,
//    valid/data stable, no overflow if engine stops within 4 cycles; drain gives exact sequence.
//  4 Engine ignores almost_full -> tx_overflow=1 and stays 1; reset clears it and all counters.
//  5 packet_len=0 -> last on every word; packet_len changed 3->5 mid-packet -> current packet
//    ends at 3 words, next at 5.
//  6 With SGD_TX_SATURATE_EN: lane input 0x7FFFFFFF -> 0x3FFFFFFF, 0x80000000 -> 0xC0000000;
//    latency N+3. Assert rst_n low mid-packet -> valid=0 immediately (async).

Source files
------------

// File: rtl/sgd_dot_product_tx.sv
// sgd_dot_product_tx: realigns skewed per-bank dot products, packs one 32-bit lane per bank and
// streams packed words out on AXI-stream. Optional macro SGD_TX_SATURATE_EN clamps lanes (+1 cycle).

module sgd_tx_fifo #(
    parameter int W     = 32,
    parameter int DEPTH = 16,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_en,
    input  logic [W-1:0]  wr_data,
    input  logic          rd_en,
    output logic [W-1:0]  rd_data,
    output logic [AW:0]   count,
    output logic          empty,
    output logic          overflow
);
    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [AW:0]   count_q, count_d;
    logic          full, do_wr, do_rd;

    assign full     = (count_q == (AW+1)'(DEPTH));
    assign empty    = (count_q == '0);
    assign do_rd    = rd_en && !empty;
    // A pop in the same cycle frees the slot, so a write to a full FIFO is still taken then.
    assign do_wr    = wr_en && (!full || do_rd);
    assign overflow = wr_en && full && !do_rd;
    assign rd_data  = mem_q[rptr_q];
    assign count    = count_q;

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (do_wr) wptr_d = wptr_q + AW'(1);
        if (do_rd) rptr_d = rptr_q + AW'(1);
        if (do_wr && !do_rd)      count_d = count_q + (AW+1)'(1);
        else if (!do_wr && do_rd) count_d = count_q - (AW+1)'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) mem_q[wptr_q] <= wr_data;
    end
endmodule

module sgd_dot_product_tx #(
    parameter int NUM_OF_BANKS = 8,
    parameter int ALIGN_DEPTH  = 16,
    parameter int OUT_DEPTH    = 64,
    parameter int AF_MARGIN    = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [15:0]               packet_len,
    input  logic [32*NUM_OF_BANKS-1:0] dot_product_signed,
    input  logic [NUM_OF_BANKS-1:0]   dot_product_signed_valid,
    output logic                      dot_product_almost_full,
    output logic                      m_axis_tx_data_tvalid,
    input  logic                      m_axis_tx_data_tready,
    output logic [32*NUM_OF_BANKS-1:0] m_axis_tx_data_tdata,
    output logic [4*NUM_OF_BANKS-1:0] m_axis_tx_data_tkeep,
    output logic                      m_axis_tx_data_tlast,
    output logic                      tx_overflow,
    output logic [31:0]               tx_word_cnt
);
    localparam int DW = 32 * NUM_OF_BANKS;
    localparam int AA = $clog2(ALIGN_DEPTH);
    localparam int OW = $clog2(OUT_DEPTH) + 1;

    // Reset asserts asynchronously but is released on a clock edge.
    logic [1:0] rst_sync_q, rst_sync_d;
    logic       rst_int_n;
    assign rst_sync_d = {rst_sync_q[0], 1'b1};
    assign rst_int_n  = rst_sync_q[1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rst_sync_q <= 2'b00;
        else        rst_sync_q <= rst_sync_d;
    end

    logic [NUM_OF_BANKS-1:0] al_empty, al_ovf, al_near;
    logic [DW-1:0]           al_data, out_wdata;
    logic                    al_pop, out_room, out_wr, out_empty, out_ovf;
    logic [OW-1:0]           out_cnt;

    for (genvar b = 0; b < NUM_OF_BANKS; b++) begin : g_align
        logic [AA:0] cnt;
        sgd_tx_fifo #(.W(32), .DEPTH(ALIGN_DEPTH)) u_fifo (
            .clk      (clk),
            .rst_n    (rst_int_n),
            .wr_en    (dot_product_signed_valid[b]),
            .wr_data  (dot_product_signed[32*b +: 32]),
            .rd_en    (al_pop),
            .rd_data  (al_data[32*b +: 32]),
            .count    (cnt),
            .empty    (al_empty[b]),
            .overflow (al_ovf[b])
        );
        assign al_near[b] = (cnt >= (AA+1)'(ALIGN_DEPTH - 4));
    end

    assign al_pop = !(|al_empty) && out_room;

`ifdef SGD_TX_SATURATE_EN
    // Values in range have bit31 == bit30; anything else clamps toward its sign.
    function automatic logic [31:0] clamp30(input logic [31:0] v);
        if (!v[31] && v[30]) return 32'h3FFF_FFFF;
        if (v[31] && !v[30]) return 32'hC000_0000;
        return v;
    endfunction

    logic          sat_vld_q, sat_vld_d;
    logic [DW-1:0] sat_data_q, sat_data_d;

    always_comb begin
        sat_vld_d  = al_pop;
        sat_data_d = sat_data_q;
        if (al_pop) begin
            for (int b = 0; b < NUM_OF_BANKS; b++)
                sat_data_d[32*b +: 32] = clamp30(al_data[32*b +: 32]);
        end
    end

    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            sat_vld_q  <= 1'b0;
            sat_data_q <= '0;
        end else begin
            sat_vld_q  <= sat_vld_d;
            sat_data_q <= sat_data_d;
        end
    end

    // Reserve a slot for the word already in the clamp stage.
    assign out_room  = (out_cnt < OW'(OUT_DEPTH - 1)) ||
                       ((out_cnt == OW'(OUT_DEPTH - 1)) && !sat_vld_q);
    assign out_wr    = sat_vld_q;
    assign out_wdata = sat_data_q;
`else
    assign out_room  = (out_cnt != OW'(OUT_DEPTH));
    assign out_wr    = al_pop;
    assign out_wdata = al_data;
`endif

    sgd_tx_fifo #(.W(DW), .DEPTH(OUT_DEPTH)) u_out (
        .clk      (clk),
        .rst_n    (rst_int_n),
        .wr_en    (out_wr),
        .wr_data  (out_wdata),
        .rd_en    (m_axis_tx_data_tready),
        .rd_data  (m_axis_tx_data_tdata),
        .count    (out_cnt),
        .empty    (out_empty),
        .overflow (out_ovf)
    );

    logic [15:0] pkt_cnt_q, pkt_cnt_d, len_q, len_d, len_in, len_eff;
    logic        hold_q, hold_d, af_q, af_d, ovf_q, ovf_d, xfer;
    logic [31:0] word_cnt_q, word_cnt_d;

    assign m_axis_tx_data_tvalid = !out_empty;
    assign m_axis_tx_data_tkeep  = '1;
    assign xfer = m_axis_tx_data_tvalid && m_axis_tx_data_tready;

    always_comb begin
        len_in  = (packet_len == 16'd0) ? 16'd1 : packet_len;
        // Word 0 samples packet_len live until it is shown; after that the latched length is used
        // so last stays stable while the word waits for ready.
        len_eff = (pkt_cnt_q == 16'd0 && !hold_q) ? len_in : len_q;
        len_d   = len_eff;
        hold_d  = m_axis_tx_data_tvalid && !m_axis_tx_data_tready;
        m_axis_tx_data_tlast = m_axis_tx_data_tvalid && (pkt_cnt_q == len_eff - 16'd1);
        pkt_cnt_d = pkt_cnt_q;
        if (xfer) pkt_cnt_d = m_axis_tx_data_tlast ? 16'd0 : pkt_cnt_q + 16'd1;
        word_cnt_d = word_cnt_q + (xfer ? 32'd1 : 32'd0);
        af_d  = (out_cnt >= OW'(OUT_DEPTH - AF_MARGIN)) || (|al_near);
        ovf_d = ovf_q || (|al_ovf) || out_ovf;
    end

    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            pkt_cnt_q  <= '0;
            len_q      <= 16'd1;
            hold_q     <= 1'b0;
            word_cnt_q <= '0;
            af_q       <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            pkt_cnt_q  <= pkt_cnt_d;
            len_q      <= len_d;
            hold_q     <= hold_d;
            word_cnt_q <= word_cnt_d;
            af_q       <= af_d;
            ovf_q      <= ovf_d;
        end
    end

    assign dot_product_almost_full = af_q;
    assign tx_overflow             = ovf_q;
    assign tx_word_cnt             = word_cnt_q;
endmodule
